// File: rtl/hough_pkg.sv
// rtl/hough_pkg.sv - shared types and size helpers for the hough frame scheduler
package hough_pkg;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    READ = 2'd3
  } bank_state_t;

  typedef enum logic {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_ACTIVE = 1'b1
  } rd_state_t;

  function automatic int pixel_count(input int width, input int height);
    return width * height;
  endfunction

  function automatic int addr_w(input int width, input int height);
    return $clog2(width * height);
  endfunction

endpackage

// File: rtl/hough_frame_scheduler.sv
// rtl/hough_frame_scheduler.sv - ping-pong bank scheduler between hysteresis writer and hough reader
// Each bank cycles FREE -> FILL -> FULL -> READ -> FREE; writer and reader FSMs only touch disjoint states.
module hough_frame_scheduler
  import hough_pkg::*;
#(
  parameter int WIDTH          = 568,
  parameter int HEIGHT         = 320,
  parameter int TIMEOUT_CYCLES = 65536,
  localparam int ADDR_W        = addr_w(WIDTH, HEIGHT)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_req,
  output logic              wr_grant,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_done,
  output logic [ADDR_W:0]   bram_wr_addr,
  output logic              rd_start,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic [ADDR_W:0]   bram_rd_addr,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic [15:0]       frame_count,
  output logic              err_short,
  output logic              err_timeout,
  output logic              err_proto,
  output logic              busy
);

  localparam int PIX    = pixel_count(WIDTH, HEIGHT);
  localparam int PIX_W  = $clog2(PIX + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  wr_state_t          r_wr_state, w_wr_state_nxt;
  rd_state_t          r_rd_state, w_rd_state_nxt;
  bank_state_t        r_bank [2];
  bank_state_t        w_bank_nxt [2];
  logic               r_wr_bank, w_wr_bank_nxt;
  logic               r_rd_bank, w_rd_bank_nxt;
  logic               r_last_full, w_last_full_nxt;
  logic [PIX_W-1:0]   r_pix, w_pix_nxt, w_pix_inc;
  logic [IDLE_W-1:0]  r_idle, w_idle_nxt;
  logic               r_wr_grant, w_wr_grant_nxt;
  logic               r_rd_start, w_rd_start_nxt;
  logic [15:0]        r_frame_count, w_frame_count_nxt;
  logic               r_err_short, w_err_short_nxt;
  logic               r_err_timeout, w_err_timeout_nxt;
  logic               r_err_proto, w_err_proto_nxt;
  logic               w_wr_sel;
  logic               w_rd_sel;
  logic               w_full0, w_full1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_state    <= W_IDLE;
      r_rd_state    <= R_IDLE;
      r_bank[0]     <= FREE;
      r_bank[1]     <= FREE;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_last_full   <= 1'b0;
      r_pix         <= '0;
      r_idle        <= '0;
      r_wr_grant    <= 1'b0;
      r_rd_start    <= 1'b0;
      r_frame_count <= '0;
      r_err_short   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_proto   <= 1'b0;
    end else begin
      r_wr_state    <= w_wr_state_nxt;
      r_rd_state    <= w_rd_state_nxt;
      r_bank[0]     <= w_bank_nxt[0];
      r_bank[1]     <= w_bank_nxt[1];
      r_wr_bank     <= w_wr_bank_nxt;
      r_rd_bank     <= w_rd_bank_nxt;
      r_last_full   <= w_last_full_nxt;
      r_pix         <= w_pix_nxt;
      r_idle        <= w_idle_nxt;
      r_wr_grant    <= w_wr_grant_nxt;
      r_rd_start    <= w_rd_start_nxt;
      r_frame_count <= w_frame_count_nxt;
      r_err_short   <= w_err_short_nxt;
      r_err_timeout <= w_err_timeout_nxt;
      r_err_proto   <= w_err_proto_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt    = r_wr_state;
    w_rd_state_nxt    = r_rd_state;
    w_bank_nxt[0]     = r_bank[0];
    w_bank_nxt[1]     = r_bank[1];
    w_wr_bank_nxt     = r_wr_bank;
    w_rd_bank_nxt     = r_rd_bank;
    w_last_full_nxt   = r_last_full;
    w_pix_nxt         = r_pix;
    w_idle_nxt        = r_idle;
    w_wr_grant_nxt    = 1'b0;
    w_rd_start_nxt    = 1'b0;
    w_frame_count_nxt = r_frame_count;
    w_err_short_nxt   = r_err_short;
    w_err_timeout_nxt = r_err_timeout;
    w_err_proto_nxt   = r_err_proto;
    w_wr_sel          = (r_bank[~r_wr_bank] == FREE) ? ~r_wr_bank : r_wr_bank;
    w_pix_inc         = (wr_en && (r_pix != PIX_W'(PIX))) ? r_pix + PIX_W'(1) : r_pix;
    w_full0           = (r_bank[0] == FULL);
    w_full1           = (r_bank[1] == FULL);
    // With both banks FULL the older one is the bank that did not complete last.
    w_rd_sel          = (w_full0 && w_full1) ? ~r_last_full : w_full1;

    case (r_wr_state)
      W_IDLE: begin
        if (wr_done) w_err_proto_nxt = 1'b1;
        if (wr_req && (r_bank[w_wr_sel] == FREE)) begin
          w_wr_bank_nxt          = w_wr_sel;
          w_bank_nxt[w_wr_sel]   = FILL;
          w_wr_grant_nxt         = 1'b1;
          w_pix_nxt              = '0;
          w_idle_nxt             = '0;
          w_wr_state_nxt         = W_ACTIVE;
        end
      end
      W_ACTIVE: begin
        w_pix_nxt = w_pix_inc;
        if (wr_done) begin
          w_bank_nxt[r_wr_bank] = FULL;
          w_last_full_nxt       = r_wr_bank;
          if (w_pix_inc != PIX_W'(PIX)) w_err_short_nxt = 1'b1;
          w_wr_state_nxt        = W_IDLE;
        end else if (wr_en) begin
          w_idle_nxt = '0;
        end else if (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          // Stalled writer: drop the partial frame so the bank can be reused.
          w_bank_nxt[r_wr_bank] = FREE;
          w_err_timeout_nxt     = 1'b1;
          w_wr_state_nxt        = W_IDLE;
        end else begin
          w_idle_nxt = r_idle + IDLE_W'(1);
        end
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase

    case (r_rd_state)
      R_IDLE: begin
        if (rd_done) w_err_proto_nxt = 1'b1;
        if (w_full0 || w_full1) begin
          w_rd_bank_nxt        = w_rd_sel;
          w_bank_nxt[w_rd_sel] = READ;
          w_rd_start_nxt       = 1'b1;
          w_rd_state_nxt       = R_ACTIVE;
        end
      end
      R_ACTIVE: begin
        if (rd_done) begin
          w_bank_nxt[r_rd_bank] = FREE;
          w_frame_count_nxt     = r_frame_count + 16'd1;
          w_rd_state_nxt        = R_IDLE;
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  assign wr_grant     = r_wr_grant;
  assign rd_start     = r_rd_start;
  assign wr_bank      = r_wr_bank;
  assign rd_bank      = r_rd_bank;
  assign frame_count  = r_frame_count;
  assign err_short    = r_err_short;
  assign err_timeout  = r_err_timeout;
  assign err_proto    = r_err_proto;
  assign busy         = (r_bank[0] != FREE) || (r_bank[1] != FREE);
  assign bram_wr_addr = {r_wr_bank, wr_addr};
  assign bram_rd_addr = {r_rd_bank, rd_addr};

endmodule

// File: tb/tb_hough_frame_scheduler.sv
// tb/tb_hough_frame_scheduler.sv - randomized directed bench with a bank-level reference model
module tb_hough_frame_scheduler;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int T   = 16;
  localparam int AW  = 4;
  localparam int PIX = W * H;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          wr_req, wr_en, wr_done, rd_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_grant, rd_start, wr_bank, rd_bank;
  logic [AW:0]   bram_wr_addr, bram_rd_addr;
  logic [15:0]   frame_count;
  logic          err_short, err_timeout, err_proto, busy;

  always #5 clock = ~clock;

  hough_frame_scheduler #(.WIDTH(W), .HEIGHT(H), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_req(wr_req), .wr_grant(wr_grant), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_done(wr_done), .bram_wr_addr(bram_wr_addr),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_done(rd_done), .bram_rd_addr(bram_rd_addr),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .frame_count(frame_count),
    .err_short(err_short), .err_timeout(err_timeout), .err_proto(err_proto), .busy(busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Bank model: 0 free, 1 filling, 2 full, 3 reading; fq holds full banks oldest first.
  int mb [2];
  int fq [$];
  int m_wb, m_rd, m_pix, m_frames;
  bit m_es, m_et, m_ep;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int m_busy();
    return (mb[0] != 0 || mb[1] != 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    mb[0] = 0; mb[1] = 0;
    fq.delete();
    m_wb = 0; m_rd = -1; m_pix = 0; m_frames = 0;
    m_es = 0; m_et = 0; m_ep = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_grant"}, wr_grant, 0);
    chk({tag, "_rd_start"}, rd_start, 0);
    chk({tag, "_wr_bank"}, wr_bank, 0);
    chk({tag, "_rd_bank"}, rd_bank, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_errs"}, {err_short, err_timeout, err_proto}, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wr_req = 0; wr_en = 0; wr_done = 0; rd_done = 0; wr_addr = '0; rd_addr = '0;
    model_reset();
    step();
    step();
    chk_all_zero("reset");
    reset_n = 1'b1;
    step();
  endtask

  task automatic expect_grant_now();
    int b;
    b = (mb[1 - m_wb] == 0) ? 1 - m_wb : m_wb;
    chk("wr_grant", wr_grant, 1);
    chk("wr_bank", wr_bank, b);
    mb[b] = 1; m_wb = b; m_pix = 0;
  endtask

  task automatic req_grant();
    wr_req = 1;
    step();
    wr_req = 0;
    expect_grant_now();
  endtask

  task automatic write_px(input int n);
    for (int i = 0; i < n; i++) begin
      wr_addr = AW'($urandom_range(0, PIX - 1));
      wr_en = 1;
      #1;
      chk("bram_wr_addr", bram_wr_addr, {m_wb[0], wr_addr});
      step();
      wr_en = 0;
      m_pix++;
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic wr_finish();
    wr_done = 1;
    step();
    wr_done = 0;
    mb[m_wb] = 2;
    fq.push_back(m_wb);
    if (m_pix != PIX) m_es = 1;
    chk("err_short", err_short, m_es);
    chk("rd_start_same_cycle", rd_start, 0);
    chk("busy_after_done", busy, m_busy());
  endtask

  task automatic expect_rd_start_now();
    int b;
    if (m_rd < 0 && fq.size() > 0) begin
      b = fq.pop_front();
      chk("rd_start", rd_start, 1);
      chk("rd_bank", rd_bank, b);
      m_rd = b; mb[b] = 3;
      rd_addr = AW'($urandom_range(0, PIX - 1));
      #1;
      chk("bram_rd_addr", bram_rd_addr, {b[0], rd_addr});
    end else begin
      chk("rd_start_idle", rd_start, 0);
    end
  endtask

  task automatic rd_finish();
    rd_done = 1;
    step();
    rd_done = 0;
    if (m_rd >= 0) begin
      mb[m_rd] = 0; m_frames++; m_rd = -1;
    end else begin
      m_ep = 1;
    end
    chk("frame_count", frame_count, m_frames & 16'hFFFF);
    chk("err_proto", err_proto, m_ep);
    chk("busy_after_rd_done", busy, m_busy());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    do_reset();

    // Basic frame: first grant lands on bank 1.
    req_grant();
    write_px(PIX);
    wr_finish();
    step();
    expect_rd_start_now();
    rd_finish();
    step();
    expect_rd_start_now();
    chk("basic_busy", busy, 0);

    // Ping-pong: writer fills one bank while the reader works on the other.
    req_grant();
    write_px(PIX);
    wr_finish();
    step();
    expect_rd_start_now();
    req_grant();
    wr_addr = AW'($urandom_range(0, PIX - 1));
    rd_addr = AW'($urandom_range(0, PIX - 1));
    #1;
    chk("pp_wr_addr", bram_wr_addr, {m_wb[0], wr_addr});
    chk("pp_rd_addr", bram_rd_addr, {m_rd[0], rd_addr});
    chk("pp_banks_differ", wr_bank ^ rd_bank, 1);
    write_px(PIX);
    wr_finish();
    step();
    expect_rd_start_now();

    // Stall: no free bank, grant follows the freeing rd_done by one cycle.
    wr_req = 1;
    repeat (3) begin
      step();
      chk("stall_no_grant", wr_grant, 0);
    end
    rd_finish();
    chk("stall_grant_not_yet", wr_grant, 0);
    step();
    expect_grant_now();
    wr_req = 0;
    expect_rd_start_now();

    // Short frame still becomes FULL and is read.
    write_px(PIX - 1);
    wr_finish();
    step();
    expect_rd_start_now();
    rd_finish();
    step();
    expect_rd_start_now();
    rd_finish();
    step();
    expect_rd_start_now();
    chk("short_busy", busy, 0);

    // Randomized frames with random reader overlap.
    for (int it = 0; it < 8; it++) begin
      while (mb[0] != 0 && mb[1] != 0) begin
        rd_finish();
        step();
        expect_rd_start_now();
      end
      req_grant();
      write_px(($urandom_range(0, 3) == 0) ? int'($urandom_range(PIX - 3, PIX - 1)) : PIX);
      wr_finish();
      step();
      expect_rd_start_now();
      if (m_rd >= 0 && $urandom_range(0, 1) == 1) begin
        rd_finish();
        step();
        expect_rd_start_now();
      end
    end
    while (m_rd >= 0) begin
      rd_finish();
      step();
      expect_rd_start_now();
    end
    chk("rand_busy", busy, 0);

    // wr_done on the last idle cycle beats the watchdog.
    req_grant();
    repeat (T - 1) step();
    wr_finish();
    chk("boundary_no_timeout", err_timeout, 0);
    step();
    expect_rd_start_now();
    rd_finish();
    step();
    expect_rd_start_now();

    // Watchdog: frame dropped after T idle cycles.
    req_grant();
    repeat (T - 1) step();
    chk("timeout_early", err_timeout, 0);
    chk("timeout_early_busy", busy, 1);
    step();
    mb[m_wb] = 0; m_et = 1;
    chk("timeout", err_timeout, m_et);
    chk("timeout_busy", busy, 0);
    step();
    chk("timeout_no_rd_start", rd_start, 0);

    // Protocol errors on each side, separated by a reset.
    wr_done = 1;
    step();
    wr_done = 0;
    m_ep = 1;
    chk("proto_wr_done", err_proto, m_ep);
    do_reset();
    rd_finish();

    // Asynchronous reset in the middle of a frame.
    req_grant();
    write_px(PIX);
    wr_finish();
    step();
    expect_rd_start_now();
    rd_finish();
    step();
    req_grant();
    write_px(3);
    chk("pre_reset_busy", busy, 1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_all_zero("async_reset");
    wr_addr = AW'($urandom_range(0, PIX - 1));
    #1;
    chk("async_reset_bram_wr", bram_wr_addr, {1'b0, wr_addr});
    step();
    reset_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
